// File: rtl/double_dabbler.sv
// Sequential binary-to-BCD converter (double dabble): one shift-add-3 iteration per
// input bit, start/done handshake, result register holds the last completed value.
module double_dabbler #(
  parameter int unsigned BIN_W  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned SW = 4 * DIGITS;
  localparam int unsigned CW = $clog2(BIN_W + 1);

  typedef enum logic {
    S_IDLE,
    S_CONV
  } state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   scratch_q, scratch_d;
  logic [BIN_W-1:0] operand_q, operand_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SW-1:0]   bcd_q, bcd_d;
  logic            done_q, done_d;
  logic [SW-1:0]   adj;
  logic [SW-1:0]   shifted;

  // Add-3 correction on each digit that is >= 5, ahead of the shift.
  always_comb begin
    adj = scratch_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end
    shifted = {adj[SW-2:0], operand_q[BIN_W-1]};
  end

  always_comb begin
    state_d   = state_q;
    scratch_d = scratch_q;
    operand_d = operand_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    done_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          operand_d = bin;
          scratch_d = '0;
          cnt_d     = '0;
          state_d   = S_CONV;
        end
      end
      S_CONV: begin
        scratch_d = shifted;
        operand_d = {operand_q[BIN_W-2:0], 1'b0};
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == CW'(BIN_W - 1)) begin
          bcd_d   = shifted;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      scratch_q <= '0;
      operand_q <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      scratch_q <= scratch_d;
      operand_q <= operand_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      done_q    <= done_d;
    end
  end

  assign bcd  = bcd_q;
  assign busy = (state_q == S_CONV);
  assign done = done_q;

endmodule

// File: tb/tb_double_dabbler.sv
// Directed bench for double_dabbler: reset, single conversions, full back-to-back
// sweep, ignored start/bin during conversion, and mid-conversion reset.
module tb_double_dabbler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  bin;
  logic [11:0] bcd;
  logic        busy;
  logic        done;

  int n_assert = 0;
  int n_fail   = 0;

  double_dabbler #(.BIN_W(8), .DIGITS(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bin   (bin),
    .bcd   (bcd),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] dec3(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Pulse start for one edge, then count edges until done (bounded).
  task automatic convert(input logic [7:0] v, input logic [11:0] exp, input string tag);
    int n;
    int busy_cnt;
    bit overlap;
    @(negedge clk);
    start = 1'b1;
    bin   = v;
    @(posedge clk);
    #1;
    start    = 1'b0;
    busy_cnt = busy ? 1 : 0;
    overlap  = 1'b0;
    n = 0;
    while (n < 20) begin
      @(posedge clk);
      #1;
      n++;
      if (busy && done) overlap = 1'b1;
      if (done) break;
      if (busy) busy_cnt++;
    end
    check({tag, "_latency"}, 32'(n), 32'd8);
    check({tag, "_bcd"}, 32'(bcd), 32'(exp));
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd8);
    check({tag, "_busy_done_overlap"}, 32'(overlap), 32'd0);
    @(posedge clk);
    #1;
    check({tag, "_done_clears"}, 32'(done), 32'd0);
  endtask

  initial begin
    int n;
    int dones;
    logic [11:0] r;

    rst_n = 1'b0;
    start = 1'b0;
    bin   = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("reset_bcd", 32'(bcd), 32'h000);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    check("idle_bcd", 32'(bcd), 32'h000);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done", 32'(done), 32'd0);

    convert(8'd0,   12'h000, "bin0");
    convert(8'd9,   12'h009, "bin9");
    convert(8'd21,  12'h021, "bin21");
    convert(8'd41,  12'h041, "bin41");
    convert(8'd108, 12'h108, "bin108");
    convert(8'd255, 12'h255, "bin255");

    // Exhaustive back-to-back sweep: start held high, next operand presented on done.
    @(negedge clk);
    start = 1'b1;
    bin   = 8'd0;
    @(posedge clk);
    #1;
    for (int v = 0; v < 256; v++) begin
      n = 0;
      while (n < 20) begin
        @(posedge clk);
        #1;
        n++;
        if (done) break;
      end
      r = bcd;
      check("sweep_period", 32'(n), (v == 0) ? 32'd8 : 32'd9);
      check("sweep_bcd", 32'(r), 32'(dec3(v)));
      check("sweep_digit_range",
            32'((r[11:8] > 4'd9) || (r[7:4] > 4'd9) || (r[3:0] > 4'd9)), 32'd0);
      if (v == 255) start = 1'b0;
      else bin = 8'(v + 1);
    end
    @(posedge clk);
    #1;
    check("sweep_end_idle", 32'(busy), 32'd0);

    // Restart and bin change three cycles into a conversion of 108.
    @(negedge clk);
    start = 1'b1;
    bin   = 8'd108;
    @(posedge clk);
    #1;
    start = 1'b0;
    dones = 0;
    for (int c = 1; c <= 14; c++) begin
      @(posedge clk);
      #1;
      if (c == 3) begin
        start = 1'b1;
        bin   = 8'd77;
      end
      if (c == 4) start = 1'b0;
      if (done) begin
        dones++;
        check("ignore_latency", 32'(c), 32'd8);
        check("ignore_bcd", 32'(bcd), 32'h108);
      end
    end
    check("ignore_single_done", 32'(dones), 32'd1);
    check("ignore_final_bcd", 32'(bcd), 32'h108);

    // Reset four cycles into a conversion aborts it.
    @(negedge clk);
    start = 1'b1;
    bin   = 8'd255;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("abort_bcd", 32'(bcd), 32'h000);
    check("abort_busy", 32'(busy), 32'd0);
    dones = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      if (done || busy) dones++;
    end
    check("abort_no_done", 32'(dones), 32'd0);
    check("abort_bcd_held", 32'(bcd), 32'h000);

    convert(8'd41, 12'h041, "post_abort41");
    convert(8'd200, 12'h200, "post_abort200");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
